mux_nx1_arb: RTL and testbench
==============================

# mux_nx1_arb

Parametrised N-input, registered, handshaked multiplexer; the successor to the team's combinational 2:1 datapath mux. Selects one of NUM_IN valid/ready input channels, either by an explicit select or by round-robin arbitration, and presents the winner through a one-entry output register with backpressure. Sits between producer datapath components and a shared consumer, such as an ALU or register-file write port.

## Interface
- DATAWIDTH, 8, bits per data channel
- NUM_IN, 4, number of input channels (2..16)
- SELWIDTH, $clog2(NUM_IN), derived localparam; width of sel and out_src

- Clk  input  1  rising-edge clock
- Rst_n  input  1  reset, asynchronous, active-low
- in_data  input  NUM_IN*DATAWIDTH  channel i at bits [i*DATAWIDTH +: DATAWIDTH]
- in_valid  input  NUM_IN  per-channel valid
- in_ready  output  NUM_IN  per-channel ready; one-hot or zero
- mode  input  1  0 = SELECT, 1 = ROUND_ROBIN
- sel  input  SELWIDTH  channel index used in SELECT mode
- out_data  output  DATAWIDTH  registered selected data
- out_valid  output  1  out_data holds a beat
- out_ready  input  1  consumer accepts the beat
- out_src  output  SELWIDTH  index of the channel that supplied out_data

## Operation
- Transfer on a channel occurs when its valid and ready are both 1 at a rising Clk edge.
- Output register accept condition: `load = !out_valid || out_ready`.
- Grant rules:
  - SELECT: grant channel `sel` when `in_valid[sel]` and sel < NUM_IN. Otherwise there is no grant.
  - ROUND_ROBIN: grant the first valid channel searching from rr_ptr upward, wrapping at NUM_IN. If no channel is valid, there is no grant.
- Ready: `in_ready[i] = load && grant_valid && (grant == i)`. in_ready never depends on in_valid[i] of a non-granted channel. in_ready may depend combinationally on out_ready.
- On a transfer, the output register captures:
  - out_data ← data of the granted channel
  - out_src ← grant
  - out_valid ← 1
- If load is 1 with no grant, out_valid ← 0; out_data and out_src hold their values.
- If out_valid && !out_ready, all output registers hold and in_ready = 0.
- rr_ptr:
  - Resets to 0.
  - After each ROUND_ROBIN transfer, rr_ptr ← (grant+1) mod NUM_IN.
  - Unchanged by SELECT-mode transfers and by mode switches.
- A mode or sel change takes effect on the same cycle combinationally. A beat already in the output register is unaffected.
- Input data is not checked; it is passed through bit-exact.

## Timing
- Reset (Rst_n low, async): out_valid = 0, out_data = 0, out_src = 0, rr_ptr = 0. While in reset, in_ready = 0.
- Release is synchronous to the first Clk edge with Rst_n high.
- Latency: 1 cycle, input transfer to out_valid.
- Throughput: 1 beat/cycle while out_ready is held high.
- Simultaneous drain and refill: when out_valid && out_ready and a grant exists, the new beat loads in the same edge and out_valid stays 1.
- Reset mid-operation: any buffered beat is discarded. No transfer is reported on the reset edge.
- Wrap-around: with rr_ptr = NUM_IN-1 and only channel 0 valid, channel 0 is granted.
- Non-power-of-two NUM_IN: sel ≥ NUM_IN yields no grant. rr_ptr never exceeds NUM_IN-1.

## Structure
- Shared package mux_pkg:
  - MODE_SELECT = 1'b0, MODE_RR = 1'b1
  - function for the SELWIDTH computation
- Sub-module rr_arbiter:
  - Parameter NUM_IN.
  - Inputs: req[NUM_IN], ptr.
  - Outputs: grant index, grant_valid.
  - Purely combinational.
  - rr_ptr register lives in the top level.
- The top level holds the grant mux, the output register and rr_ptr.

## Test plan
- Reset: assert Rst_n=0 mid-stream with out_valid=1 → out_valid, out_data and out_src drop to 0 immediately, without a Clk edge. After release, the first transfer occurs no earlier than the next edge.
- SELECT: NUM_IN=4, mode=0, sel=2, all valid, in_data ch2=8'hA5, out_ready=1 → in_ready=4'b0100. Next cycle out_data=8'hA5, out_src=2. With sel=3 and in_valid[3]=0 → no transfer and out_valid falls to 0.
- ROUND_ROBIN fairness: all four channels valid continuously, out_ready=1 → out_src sequence 0,1,2,3,0,1 on consecutive cycles.
- Wrap/sparse: rr_ptr=3 and only channels 0 and 2 valid → grant 0, then 2, then 0.
- Backpressure: out_ready=0 for 3 cycles while out_valid=1 → out_data and out_src stable, in_ready=0. The cycle out_ready returns to 1, the next beat loads with no bubble.
- NUM_IN=3 with sel=3 → no grant ever. In ROUND_ROBIN, rr_ptr sequence stays within 0..2.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared definitions for the N:1 handshaked multiplexer family.
//   MODE_SELECT / MODE_RR : values of the mode input
//   sel_width()           : width of a channel index for a given channel count
package mux_pkg;

  localparam logic MODE_SELECT = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  localparam int unsigned MIN_IN = 2;
  localparam int unsigned MAX_IN = 16;

  // Smallest width able to index n channels; never below 1 bit.
  function automatic int unsigned sel_width(input int unsigned n);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester found
// searching upward from ptr_i, wrapping at NUM_IN.
//   req_i         : per-channel request
//   ptr_i         : highest-priority channel index (must be < NUM_IN)
//   grant_o       : index of the winning channel (0 when nothing requests)
//   grant_valid_o : at least one channel requested
module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int unsigned NUM_IN   = 4,
  localparam int unsigned SELWIDTH = sel_width(NUM_IN)
) (
  input  logic [NUM_IN-1:0]   req_i,
  input  logic [SELWIDTH-1:0] ptr_i,
  output logic [SELWIDTH-1:0] grant_o,
  output logic                grant_valid_o
);

  logic [NUM_IN-1:0] req_hi;

  // Requests at or above the pointer win first; otherwise wrap to the
  // lowest requester overall.
  always_comb begin
    req_hi        = '0;
    grant_o       = '0;
    grant_valid_o = 1'b0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      req_hi[i] = req_i[i] && (SELWIDTH'(i) >= ptr_i);
    end
    for (int i = int'(NUM_IN) - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        grant_o       = SELWIDTH'(i);
        grant_valid_o = 1'b1;
      end
    end
    if (|req_hi) begin
      for (int i = int'(NUM_IN) - 1; i >= 0; i--) begin
        if (req_hi[i]) grant_o = SELWIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/mux_nx1_arb.sv
// Registered N:1 valid/ready multiplexer with explicit-select or
// round-robin channel choice and a one-entry output register.
//   clk, rst_n : clock, asynchronous active-low reset
//   in_data    : NUM_IN packed channels, channel i at [i*DATAWIDTH +: DATAWIDTH]
//   in_valid   : per-channel valid
//   in_ready   : per-channel ready, one-hot or zero (combinational)
//   mode       : MODE_SELECT or MODE_RR
//   sel        : channel index used in MODE_SELECT
//   out_data   : registered beat
//   out_valid  : out_data holds a beat
//   out_ready  : consumer accepts the beat
//   out_src    : channel that supplied out_data
module mux_nx1_arb
  import mux_pkg::*;
#(
  parameter  int unsigned DATAWIDTH = 8,
  parameter  int unsigned NUM_IN    = 4,
  localparam int unsigned SELWIDTH  = sel_width(NUM_IN)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_IN*DATAWIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]           in_valid,
  output logic [NUM_IN-1:0]           in_ready,
  input  logic                        mode,
  input  logic [SELWIDTH-1:0]         sel,
  output logic [DATAWIDTH-1:0]        out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [SELWIDTH-1:0]         out_src
);

  localparam logic [SELWIDTH-1:0] LAST_IDX = SELWIDTH'(NUM_IN - 1);

  logic                 out_valid_q, out_valid_d;
  logic [DATAWIDTH-1:0] out_data_q,  out_data_d;
  logic [SELWIDTH-1:0]  out_src_q,   out_src_d;
  logic [SELWIDTH-1:0]  rr_ptr_q,    rr_ptr_d;

  logic                 load_c;
  logic                 sel_gv_c;
  logic [SELWIDTH-1:0]  rr_grant_c;
  logic                 rr_gv_c;
  logic [SELWIDTH-1:0]  grant_c;
  logic                 grant_valid_c;
  logic [DATAWIDTH-1:0] grant_data_c;

  rr_arbiter #(
    .NUM_IN (NUM_IN)
  ) u_rr_arbiter (
    .req_i         (in_valid),
    .ptr_i         (rr_ptr_q),
    .grant_o       (rr_grant_c),
    .grant_valid_o (rr_gv_c)
  );

  // Output register can take a beat when empty or being drained this cycle.
  assign load_c = !out_valid_q || out_ready;

  // Explicit select: an out-of-range sel matches no channel, so never grants.
  always_comb begin
    sel_gv_c = 1'b0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if ((sel == SELWIDTH'(i)) && in_valid[i]) sel_gv_c = 1'b1;
    end
  end

  // Grant choice follows mode combinationally.
  always_comb begin
    grant_c       = sel;
    grant_valid_c = sel_gv_c;
    if (mode == MODE_RR) begin
      grant_c       = rr_grant_c;
      grant_valid_c = rr_gv_c;
    end
  end

  // Data mux for the granted channel.
  always_comb begin
    grant_data_c = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (grant_c == SELWIDTH'(i)) grant_data_c = in_data[i*DATAWIDTH +: DATAWIDTH];
    end
  end

  // Ready goes only to the granted channel; held low while in reset.
  always_comb begin
    in_ready = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      in_ready[i] = rst_n && load_c && grant_valid_c && (grant_c == SELWIDTH'(i));
    end
  end

  // Next-state for the output register and round-robin pointer.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    rr_ptr_d    = rr_ptr_q;
    if (load_c) begin
      if (grant_valid_c) begin
        out_valid_d = 1'b1;
        out_data_d  = grant_data_c;
        out_src_d   = grant_c;
        if (mode == MODE_RR) begin
          rr_ptr_d = (grant_c == LAST_IDX) ? '0 : grant_c + SELWIDTH'(1);
        end
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule

// File: tb/tb_mux_nx1_arb.sv
// Bench for mux_nx1_arb: a 4-channel and a 3-channel instance driven side by
// side and compared against a transaction-level model of the grant rules.
module tb_mux_nx1_arb;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: NUM_IN = 4
  logic [31:0] a_data;
  logic [3:0]  a_valid, a_ready;
  logic        a_mode, a_ordy, a_ovalid;
  logic [1:0]  a_sel, a_osrc;
  logic [7:0]  a_odata;

  // Instance B: NUM_IN = 3 (non-power-of-two)
  logic [23:0] b_data;
  logic [2:0]  b_valid, b_ready;
  logic        b_mode, b_ordy, b_ovalid;
  logic [1:0]  b_sel, b_osrc;
  logic [7:0]  b_odata;

  mux_nx1_arb #(.DATAWIDTH(8), .NUM_IN(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
    .mode(a_mode), .sel(a_sel), .out_data(a_odata), .out_valid(a_ovalid),
    .out_ready(a_ordy), .out_src(a_osrc)
  );

  mux_nx1_arb #(.DATAWIDTH(8), .NUM_IN(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
    .mode(b_mode), .sel(b_sel), .out_data(b_odata), .out_valid(b_ovalid),
    .out_ready(b_ordy), .out_src(b_osrc)
  );

  int tests = 0;
  int fails = 0;
  bit b_auto = 1'b1;

  // Reference model state per instance (0 = A, 1 = B).
  int         n_m   [2] = '{4, 3};
  bit         ov_m  [2];
  logic [7:0] od_m  [2];
  int         os_m  [2];
  int         ptr_m [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Winner under the grant rules, -1 when there is none.
  function automatic int grant_of(input int n, input bit md, input int s,
                                  input logic [15:0] v, input int p);
    if (!md) return (s < n && v[s] === 1'b1) ? s : -1;
    for (int k = 0; k < n; k++) begin
      int c;
      c = (p + k) % n;
      if (v[c] === 1'b1) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      ov_m[d] = 1'b0; od_m[d] = 8'h00; os_m[d] = 0; ptr_m[d] = 0;
    end
  endtask

  // Checks ready for the current inputs and advances the model by one edge.
  task automatic model_cycle(input int d, input bit md, input int s, input logic [15:0] v,
                             input logic [127:0] data, input bit ordy,
                             input logic [15:0] ready_obs, input string tag);
    bit            load;
    int            g;
    logic [15:0]   exp_r;
    logic [127:0]  sh;
    load  = !ov_m[d] || ordy;
    g     = grant_of(n_m[d], md, s, v, ptr_m[d]);
    exp_r = (load && g >= 0) ? (16'd1 << g) : 16'd0;
    chk({tag, ".in_ready"}, 32'(ready_obs), 32'(exp_r));
    if (load) begin
      if (g >= 0) begin
        sh      = data >> (8 * g);
        ov_m[d] = 1'b1;
        od_m[d] = sh[7:0];
        os_m[d] = g;
        if (md) ptr_m[d] = (g + 1) % n_m[d];
      end else begin
        ov_m[d] = 1'b0;
      end
    end
  endtask

  task automatic check_outputs();
    chk("A.out_valid", 32'(a_ovalid), 32'(ov_m[0]));
    chk("A.out_data",  32'(a_odata),  32'(od_m[0]));
    chk("A.out_src",   32'(a_osrc),   32'(os_m[0]));
    chk("B.out_valid", 32'(b_ovalid), 32'(ov_m[1]));
    chk("B.out_data",  32'(b_odata),  32'(od_m[1]));
    chk("B.out_src",   32'(b_osrc),   32'(os_m[1]));
  endtask

  task automatic rand_b();
    b_mode  = 1'($urandom);
    b_sel   = 2'($urandom);
    b_valid = 3'($urandom);
    b_data  = 24'($urandom);
    b_ordy  = ($urandom % 4) != 0;
  endtask

  task automatic rand_a();
    a_mode  = 1'($urandom);
    a_sel   = 2'($urandom);
    a_valid = 4'($urandom);
    a_data  = $urandom;
    a_ordy  = ($urandom % 4) != 0;
  endtask

  // Called at a negedge with inputs driven; returns at the following negedge.
  task automatic step();
    if (b_auto) rand_b();
    #1;
    model_cycle(0, a_mode, int'(a_sel), 16'(a_valid), 128'(a_data), a_ordy, 16'(a_ready), "A");
    model_cycle(1, b_mode, int'(b_sel), 16'(b_valid), 128'(b_data), b_ordy, 16'(b_ready), "B");
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    logic [7:0] held_data;
    logic [1:0] held_src;
    int         exp_sparse [3] = '{0, 2, 0};

    // Reset: outputs zero and no ready even with every channel valid.
    a_mode = 1'b0; a_sel = 2'd0; a_valid = 4'hF; a_data = 32'h0; a_ordy = 1'b1;
    rand_b();
    b_valid = 3'h7;
    model_reset();
    #2;
    chk("rst.A.in_ready", 32'(a_ready), 32'h0);
    chk("rst.B.in_ready", 32'(b_ready), 32'h0);
    @(negedge clk);
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;

    // SELECT sel=2, all valid: only channel 2 ready, its byte appears next cycle.
    a_mode = 1'b0; a_sel = 2'd2; a_valid = 4'hF; a_data = 32'h44A52233; a_ordy = 1'b1;
    #1;
    chk("sel2.in_ready", 32'(a_ready), 32'h4);
    step();
    chk("sel2.out_data", 32'(a_odata), 32'hA5);
    chk("sel2.out_src",  32'(a_osrc),  32'd2);
    chk("sel2.out_valid", 32'(a_ovalid), 32'd1);

    // SELECT sel=3 with channel 3 idle: no transfer, out_valid falls.
    a_sel = 2'd3; a_valid = 4'b0111;
    #1;
    chk("sel3.in_ready", 32'(a_ready), 32'h0);
    step();
    chk("sel3.out_valid", 32'(a_ovalid), 32'd0);
    chk("sel3.out_data",  32'(a_odata),  32'hA5);

    // Round-robin fairness from pointer 0 (untouched by SELECT transfers).
    a_mode = 1'b1; a_valid = 4'hF;
    for (int k = 0; k < 6; k++) begin
      a_data = $urandom;
      step();
      chk($sformatf("rr_fair%0d.out_src", k), 32'(a_osrc), 32'(k % 4));
      chk($sformatf("rr_fair%0d.out_valid", k), 32'(a_ovalid), 32'd1);
    end

    // Move pointer to 3, then sparse channels 0 and 2 wrap: 0, 2, 0.
    a_valid = 4'b0100;
    step();
    chk("ptr3.out_src", 32'(a_osrc), 32'd2);
    a_valid = 4'b0101;
    for (int k = 0; k < 3; k++) begin
      a_data = $urandom;
      step();
      chk($sformatf("sparse%0d.out_src", k), 32'(a_osrc), 32'(exp_sparse[k]));
    end

    // Backpressure for 3 cycles, then reload without a bubble.
    a_valid = 4'hF; a_ordy = 1'b0;
    held_data = a_odata; held_src = a_osrc;
    for (int k = 0; k < 3; k++) begin
      a_data = $urandom;
      #1;
      chk($sformatf("bp%0d.in_ready", k), 32'(a_ready), 32'h0);
      step();
      chk($sformatf("bp%0d.out_data", k), 32'(a_odata), 32'(held_data));
      chk($sformatf("bp%0d.out_src", k),  32'(a_osrc),  32'(held_src));
      chk($sformatf("bp%0d.out_valid", k), 32'(a_ovalid), 32'd1);
    end
    a_ordy = 1'b1; a_data = 32'h00C30000 | 32'h00005A00;
    step();
    chk("bp_release.out_valid", 32'(a_ovalid), 32'd1);
    chk("bp_release.out_src",   32'(a_osrc),   32'd1);
    chk("bp_release.out_data",  32'(a_odata),  32'h5A);

    // NUM_IN=3 instance with sel=3: never granted.
    b_auto = 1'b0;
    b_mode = 1'b0; b_sel = 2'd3; b_valid = 3'h7; b_data = 24'hABCDEF; b_ordy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("b_sel3_%0d.in_ready", k), 32'(b_ready), 32'h0);
      step();
      chk($sformatf("b_sel3_%0d.out_valid", k), 32'(b_ovalid), 32'd0);
    end
    b_auto = 1'b1;

    // Random traffic on both instances.
    for (int k = 0; k < 400; k++) begin
      rand_a();
      step();
      chk("B.out_src_range", 32'(b_osrc < 2'd3), 32'd1);
    end

    // Mid-stream asynchronous reset with a buffered beat.
    a_mode = 1'b1; a_valid = 4'hF; a_ordy = 1'b1; a_data = $urandom;
    step();
    a_ordy = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst.out_valid", 32'(a_ovalid), 32'd0);
    chk("midrst.out_data",  32'(a_odata),  32'd0);
    chk("midrst.out_src",   32'(a_osrc),   32'd0);
    chk("midrst.in_ready",  32'(a_ready),  32'd0);
    chk("midrst.B.out_valid", 32'(b_ovalid), 32'd0);
    model_reset();
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    check_outputs();
    step();
    chk("postrst.out_valid", 32'(a_ovalid), 32'd1);
    chk("postrst.out_src",   32'(a_osrc),   32'd0);

    for (int k = 0; k < 200; k++) begin
      rand_a();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
